bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit phase; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 4: anti-ghost blank cycles at the start of each phase; legal range 1..REFRESH_DIV-2.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 bcd_in  in  8  packed two-digit BCD; [7:4] tens, [3:0] units.
REQ-006 load  in  1  capture strobe; bcd_in is sampled on any rising edge where load=1.
REQ-007 blank_lz  in  1  1 = suppress the tens digit when it is zero.
REQ-008 an  out  2  digit enables, active-low; an[0] units, an[1] tens.
REQ-009 seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.
REQ-010 bcd_err  out  1  1 = last captured value holds a nibble greater than 9.

Function
REQ-011 A shadow register SHALL load bcd_in on every edge with load=1 and hold otherwise; the display SHALL be driven from the shadow register only.
REQ-012 bcd_err SHALL be registered and updated on the same edge as the shadow register: 1 if either nibble of bcd_in exceeds 9, else 0.
REQ-013 Scan FSM states: IDLE, D0 (units), D1 (tens).
- IDLE -> D0 on the first edge after reset release.
- D0 -> D1 and D1 -> D0 when the phase divider equals REFRESH_DIV-1.
REQ-014 Phase divider SHALL clear on every state change and on entry from IDLE, and SHALL otherwise increment by 1 per cycle.
REQ-015 In IDLE, and while divider < BLANK_CYC, an SHALL be 2'b11.
- At all other times in D0: an = 2'b10.
- At all other times in D1: an = 2'b01.
REQ-016 In D1, when blank_lz=1 and the shadow tens nibble = 0, an SHALL stay 2'b11 for the whole phase; phase timing is unchanged.
REQ-017 Segment decode (hex) SHALL be:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Any nibble A..F = 3F (dash).
REQ-018 seg SHALL show the units nibble in D0 and the tens nibble in D1; seg SHALL be 7F whenever an = 2'b11.
REQ-019 an and seg SHALL be registered outputs.
- Output latency: one cycle from state/divider.
- Output latency: two edges from a load edge to the new value on seg, when the digit is enabled.
REQ-020 A load coinciding with a phase switch SHALL take effect as in REQ-019; no phase is lengthened or skipped.
REQ-021 blank_lz SHALL be sampled every cycle and has no retained state.
REQ-022 an SHALL never be 2'b00.

Reset
REQ-023 While rst_n=0, regardless of clk:
- shadow = 8'h00, bcd_err = 0, FSM = IDLE, divider = 0.
- an = 2'b11, seg = 7'h7F.
REQ-024 Reset asserted mid-phase SHALL blank the outputs immediately, asynchronously.
REQ-025 After reset release, scanning SHALL restart from D0 with divider 0.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-026 Reset release, no load, blank_lz=0:
- an = 11 for 2 cycles of D0, then an = 10 with seg = 40 for 6 cycles.
- Then D1 shows the same pattern with an = 01.
REQ-027 load with bcd_in = 8'h90, blank_lz=1:
- D0 phase: seg = 40.
- D1 phase: seg = 10.
- bcd_err = 0.
REQ-028 load with bcd_in = 8'h05, blank_lz=1:
- D1 phase: an = 11, seg = 7F throughout.
- Same input with blank_lz=0: D1 phase shows seg = 40.
REQ-029 load with bcd_in = 8'h9A:
- bcd_err = 1 on the next cycle.
- D0 phase: seg = 3F.
- A following load of 8'h99 clears bcd_err.
REQ-030 Sequence checks:
- Load 8'h99 then 8'h00 on consecutive cycles during D0 steady display: seg changes 10 -> 40 exactly two edges after each load.
- rst_n pulsed low mid-D1: an = 11 and seg = 7F without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed BCD display driver.
// A load-strobed shadow register feeds a two-phase scan (units, tens) with
// anti-ghost blanking at the start of each phase and optional leading-zero
// suppression on the tens digit. Digit enables and segments are active-low
// and registered.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       bcd_err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic [1:0] {
        IDLE,
        D0,
        D1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  div;
    logic [CW-1:0]  div_nx;
    logic [7:0]     shadow;
    logic [1:0]     an_nx;
    logic [6:0]     seg_nx;

    // Active-low {g,f,e,d,c,b,a}; any non-decimal nibble shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Capture the displayed value and its validity flag on every load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            bcd_err <= 1'b0;
        end else if (load) begin
            shadow  <= bcd_in;
            bcd_err <= (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
        end
    end

    // Scan state and phase divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= '0;
        end else begin
            state <= state_nx;
            div   <= div_nx;
        end
    end

    // Next-state: alternate units/tens phases every REFRESH_DIV cycles.
    always_comb begin
        state_nx = state;
        div_nx   = div + CW'(1);
        case (state)
            IDLE: begin
                state_nx = D0;
                div_nx   = '0;
            end
            D0: begin
                if (div == DIV_LAST) begin
                    state_nx = D1;
                    div_nx   = '0;
                end
            end
            D1: begin
                if (div == DIV_LAST) begin
                    state_nx = D0;
                    div_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                div_nx   = '0;
            end
        endcase
    end

    // Output decode: blank during the anti-ghost window and for a suppressed leading zero.
    always_comb begin
        an_nx  = '1;
        seg_nx = '1;
        case (state)
            D0: begin
                if (div >= BLANK_END) begin
                    an_nx  = 2'b10;
                    seg_nx = seg_decode(shadow[3:0]);
                end
            end
            D1: begin
                if (div >= BLANK_END && !(blank_lz && shadow[7:4] == 4'd0)) begin
                    an_nx  = 2'b01;
                    seg_nx = seg_decode(shadow[7:4]);
                end
            end
            default: begin
                an_nx  = '1;
                seg_nx = '1;
            end
        endcase
    end

    // Registered digit enables and segments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with REFRESH_DIV=8, BLANK_CYC=2.
// Expected outputs are queued against the post-reset edge number at which
// they must appear; a negedge monitor compares and retires them.
module tb_bcd_display_scan;

    logic       clk;
    logic       rst_n;
    logic [7:0] bcd_in;
    logic       load;
    logic       blank_lz;
    logic [1:0] an;
    logic [6:0] seg;
    logic       bcd_err;

    int errors = 0;
    int checks = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t sb[$];

    bcd_display_scan #(
        .REFRESH_DIV(8),
        .BLANK_CYC  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bcd_in  (bcd_in),
        .load    (load),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .bcd_err (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: edge 1 is the first rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;
            4'd3: s = 7'h30;  4'd4: s = 7'h19;  4'd5: s = 7'h12;
            4'd6: s = 7'h02;  4'd7: s = 7'h78;  4'd8: s = 7'h00;
            4'd9: s = 7'h10;  default: s = 7'h3F;
        endcase
        return s;
    endfunction

    task automatic push(input int c, input logic [1:0] a, input logic [6:0] s, input logic e);
        exp_t x;
        x.cyc = c; x.an = a; x.seg = s; x.err = e;
        sb.push_back(x);
    endtask

    // Phase p spans edges 2+8p .. 9+8p; first two edges blanked; even p = units.
    task automatic expect_phase(input int p, input logic [3:0] digit, input bit shown,
                                input logic err, input int upto);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = 2 + 8 * p + k;
            if (c <= upto) begin
                if (k < 2 || !shown) push(c, 2'b11, 7'h7F, err);
                else push(c, (p % 2 == 0) ? 2'b10 : 2'b01, seg_of(digit), err);
            end
        end
    endtask

    task automatic check_now(input string name, input logic [1:0] a, input logic [6:0] s,
                             input logic e);
        checks++;
        if (an !== a || seg !== s || bcd_err !== e) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h err=%b, want an=%b seg=%h err=%b",
                     name, an, seg, bcd_err, a, s, e);
        end
    endtask

    // Monitor: retire every queued expectation due at the current edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checks++;
                    if (an !== sb[i].an || seg !== sb[i].seg || bcd_err !== sb[i].err) begin
                        errors++;
                        $display("FAIL scan cyc=%0d: got an=%b seg=%h err=%b, want an=%b seg=%h err=%b",
                                 cyc, an, seg, bcd_err, sb[i].an, sb[i].seg, sb[i].err);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic goto(input int n);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc != n && g < 2000);
        if (cyc != n) begin
            errors++;
            checks++;
            $display("FAIL goto: edge count %0d, want %0d", cyc, n);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "edge counter stalled");
        end
    endtask

    initial begin
        rst_n = 1'b1; load = 1'b0; bcd_in = 8'h00; blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_now("reset_async", 2'b11, 7'h7F, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_now("reset_held", 2'b11, 7'h7F, 1'b0);

        // Default scan of 00, leading zero shown.
        push(1, 2'b11, 7'h7F, 1'b0);
        expect_phase(0, 4'h0, 1, 1'b0, 999);
        expect_phase(1, 4'h0, 1, 1'b0, 999);
        @(negedge clk) rst_n = 1'b1;

        // 0x90 with suppression on: tens nonzero so still shown.
        goto(17);
        load = 1'b1; bcd_in = 8'h90; blank_lz = 1'b1;
        expect_phase(2, 4'h0, 1, 1'b0, 999);
        expect_phase(3, 4'h9, 1, 1'b0, 999);
        goto(18); load = 1'b0;

        // 0x05: tens suppressed, then shown once blank_lz drops.
        goto(33);
        load = 1'b1; bcd_in = 8'h05;
        expect_phase(4, 4'h5, 1, 1'b0, 999);
        expect_phase(5, 4'h0, 0, 1'b0, 999);
        goto(34); load = 1'b0;
        goto(49);
        blank_lz = 1'b0;
        expect_phase(6, 4'h5, 1, 1'b0, 999);
        expect_phase(7, 4'h0, 1, 1'b0, 999);

        // 0x9A flags an error and dashes the units; 0x99 clears it.
        goto(65);
        load = 1'b1; bcd_in = 8'h9A;
        expect_phase(8, 4'hA, 1, 1'b1, 999);
        expect_phase(9, 4'h9, 1, 1'b1, 999);
        goto(66); load = 1'b0;
        goto(81);
        load = 1'b1; bcd_in = 8'h99;
        expect_phase(10, 4'h9, 1, 1'b0, 999);
        goto(82); load = 1'b0;

        // Load 0x04 on a phase switch, then 0x99, 0x00 back-to-back mid-D0.
        goto(89);
        load = 1'b1; bcd_in = 8'h04;
        expect_phase(11, 4'h0, 1, 1'b0, 999);
        push(98, 2'b11, 7'h7F, 1'b0);
        push(99, 2'b11, 7'h7F, 1'b0);
        push(100, 2'b10, 7'h19, 1'b0);
        push(101, 2'b10, 7'h19, 1'b0);
        push(102, 2'b10, 7'h10, 1'b0);
        push(103, 2'b10, 7'h40, 1'b0);
        push(104, 2'b10, 7'h40, 1'b0);
        push(105, 2'b10, 7'h40, 1'b0);
        expect_phase(13, 4'h0, 1, 1'b0, 109);
        goto(90); load = 1'b0;
        goto(100); load = 1'b1; bcd_in = 8'h99;
        goto(101); bcd_in = 8'h00;
        goto(102); load = 1'b0;

        // Reset mid-D1 blanks immediately; scanning restarts from D0.
        goto(109);
        #2 rst_n = 1'b0;
        #1 check_now("reset_mid_d1", 2'b11, 7'h7F, 1'b0);
        @(posedge clk);
        #1 check_now("reset_mid_hold", 2'b11, 7'h7F, 1'b0);
        push(1, 2'b11, 7'h7F, 1'b0);
        expect_phase(0, 4'h0, 1, 1'b0, 999);
        @(negedge clk) rst_n = 1'b1;
        goto(10);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL missed: expectation for cyc=%0d never compared", sb[i].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
